// File: rtl/stopwatch_time_counter_pkg.sv
// Shared types and helpers for the stopwatch time counter slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package stopwatch_pkg;

  // Control FSM encoding; the top maps these onto plain logic [1:0] constants.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    PAUSED    = 2'd2,
    SATURATED = 2'd3
  } state_e;

  // Largest value a BCD digit may hold; every digit compare is against this, never 15.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Board-clock cycles per count tick (callers guarantee the result is >= 2).
  function automatic int tick_divisor(input int board_hz, input int tick_hz);
    return board_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_time_counter_if.sv
// Control pulses in and packed BCD time out for the stopwatch counter.
// Latency: none (wiring only).
// Backpressure: none; the controls are single-cycle pulses, the outputs are levels.
interface stopwatch_time_counter_if;

  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] number;
  logic        running;
  logic        overflow;

  // Button/debounce side drives the pulses and reads the time.
  modport master (
    output start_stop, clear, lap,
    input  number, running, overflow
  );

  // Counter side.
  modport slave (
    input  start_stop, clear, lap,
    output number, running, overflow
  );

endinterface

// File: rtl/stopwatch_time_counter_bcd.sv
// Single BCD decade (0..9) with clear, increment and ripple carry out.
// Latency: digit updates on the edge after inc; carry is combinational.
// Backpressure: none; inc is consumed every cycle it is high.
module bcd_decade_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  // Carry only when this decade is about to roll over from 9.
  assign carry = inc & (digit == BCD_MAX);

  // Digit register: clear wins, otherwise step 0..9 and wrap on carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timebase + 4-digit BCD accumulator (d3 d2 . d1 d0), optional lap hold via STOPWATCH_LAP_HOLD_EN.
// Latency: number changes on the edge after the prescaler tick; first increment DIV cycles after start.
// Backpressure: none; control pulses act on the cycle they are seen, clear beats start_stop.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int TICK_RATE_IN_HZ             = 100,
  parameter int NUMBER_OF_DIGITS            = 4   // fixed at 4 for the dd.dd format
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stopwatch_time_counter_if.slave bus
);

  localparam int DIV = tick_divisor(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_RATE_IN_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_RUNNING   = RUNNING;
  localparam logic [1:0] ST_PAUSED    = PAUSED;
  localparam logic [1:0] ST_SATURATED = SATURATED;

  logic [1:0]                    state;
  logic [1:0]                    state_nxt;
  logic [PW-1:0]                 prescaler;
  logic                          is_running;
  logic                          tick;
  logic                          all_nines;
  logic                          sat_hit;
  logic [3:0]                    digit [NUMBER_OF_DIGITS];
  logic [NUMBER_OF_DIGITS-1:0]   inc;
  logic [NUMBER_OF_DIGITS-1:0]   carry;
  logic [4*NUMBER_OF_DIGITS-1:0] live_number;
  logic                          top_carry_unused;

  assign is_running = (state == ST_RUNNING);
  assign tick       = is_running & (prescaler == PRE_MAX);

  // All decades at 9: the next tick would wrap, so it is swallowed and we saturate.
  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
      all_nines = all_nines & (digit[i] == BCD_MAX);
    end
  end

  assign sat_hit = tick & all_nines;

  // Decade chain: the tick feeds d0, each carry feeds the next decade in the same cycle.
  assign inc[0] = tick & ~sat_hit;

  for (genvar g = 0; g < NUMBER_OF_DIGITS; g++) begin : g_decade
    if (g > 0) begin : g_chain
      assign inc[g] = carry[g-1];
    end

    bcd_decade_counter u_decade (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clear),
      .inc   (inc[g]),
      .digit (digit[g]),
      .carry (carry[g])
    );

    assign live_number[4*g +: 4] = digit[g];
  end

  // The top carry can never fire because saturation gates the tick.
  assign top_carry_unused = carry[NUMBER_OF_DIGITS-1];

  // Prescaler: free-runs only in RUNNING; starting from IDLE or clearing restarts the partial tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (bus.clear) begin
      prescaler <= '0;
    end else if ((state == ST_IDLE) && bus.start_stop) begin
      prescaler <= '0;
    end else if (is_running) begin
      prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + PW'(1);
    end
  end

  // Next-state logic; clear overrides everything, saturation beats a same-cycle pause.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start_stop) state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (sat_hit)             state_nxt = ST_SATURATED;
        else if (bus.start_stop) state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (bus.start_stop) state_nxt = ST_RUNNING;
      end
      ST_SATURATED: begin
        state_nxt = ST_SATURATED;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (bus.clear) state_nxt = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign bus.running  = is_running;
  assign bus.overflow = (state == ST_SATURATED);

`ifdef STOPWATCH_LAP_HOLD_EN
  logic        hold;
  logic [15:0] lap_reg;

  // Lap toggles a frozen snapshot while running; the live count keeps going underneath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= 1'b0;
      lap_reg <= 16'h0000;
    end else if (bus.clear) begin
      hold    <= 1'b0;
      lap_reg <= 16'h0000;
    end else if (is_running && bus.lap) begin
      if (hold) begin
        hold <= 1'b0;
      end else begin
        hold    <= 1'b1;
        lap_reg <= live_number;
      end
    end
  end

  assign bus.number = hold ? lap_reg : live_number;
`else
  logic lap_unused;

  assign lap_unused = bus.lap;
  assign bus.number = live_number;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for stopwatch_time_counter: DIV=10 instance for timing, DIV=2 instance for saturation.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Optional lap-hold expectations follow STOPWATCH_LAP_HOLD_EN.
module tb_stopwatch_time_counter;

  logic clk = 1'b0;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  stopwatch_time_counter_if bus ();
  stopwatch_time_counter_if fbus ();

  stopwatch_time_counter #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ (1000),
    .TICK_RATE_IN_HZ             (100),
    .NUMBER_OF_DIGITS            (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stopwatch_time_counter #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ (1000),
    .TICK_RATE_IN_HZ             (500),
    .NUMBER_OF_DIGITS            (4)
  ) dut_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] lap_expect;

  initial begin
    rst_n = 1'b0;
    bus.start_stop = 1'b0;  bus.clear = 1'b0;  bus.lap = 1'b0;
    fbus.start_stop = 1'b0; fbus.clear = 1'b0; fbus.lap = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    lap_expect = 16'h0123;
`else
    lap_expect = 16'h0143;
`endif

    #2;
    check("rst_number",   bus.number,            16'h0000);
    check("rst_running",  16'(bus.running),      16'h0000);
    check("rst_overflow", 16'(bus.overflow),     16'h0000);
    cycles(2);
    rst_n = 1'b1;

    cycles(50);
    check("idle_number",   bus.number,        16'h0000);
    check("idle_running",  16'(bus.running),  16'h0000);
    check("idle_overflow", 16'(bus.overflow), 16'h0000);

    // Start; first increment exactly 10 cycles after the start edge.
    bus.start_stop = 1'b1; cycles(1); bus.start_stop = 1'b0;
    check("start_running", 16'(bus.running), 16'h0001);
    cycles(9);
    check("first_tick_early", bus.number, 16'h0000);
    cycles(1);
    check("first_tick", bus.number, 16'h0001);
    cycles(80);
    check("count_0009", bus.number, 16'h0009);
    cycles(10);
    check("carry_0010", bus.number, 16'h0010);
    cycles(9890);
    check("count_0999", bus.number, 16'h0999);
    cycles(10);
    check("triple_carry_1000", bus.number, 16'h1000);

    // Pause so the prescaler freezes at 4.
    cycles(3);
    bus.start_stop = 1'b1; cycles(1); bus.start_stop = 1'b0;
    check("pause_running", 16'(bus.running), 16'h0000);
    cycles(100);
    check("pause_hold", bus.number, 16'h1000);

    // Resume: the remaining partial tick takes 6 cycles.
    bus.start_stop = 1'b1; cycles(1); bus.start_stop = 1'b0;
    check("resume_running", 16'(bus.running), 16'h0001);
    cycles(5);
    check("resume_early", bus.number, 16'h1000);
    cycles(1);
    check("resume_tick", bus.number, 16'h1001);

    // start_stop and clear together while running: clear wins.
    bus.start_stop = 1'b1; bus.clear = 1'b1; cycles(1);
    bus.start_stop = 1'b0; bus.clear = 1'b0;
    check("ss_clear_number",  bus.number,       16'h0000);
    check("ss_clear_running", 16'(bus.running), 16'h0000);
    cycles(30);
    check("ss_clear_stays", bus.number, 16'h0000);

    // Lap behaviour (held snapshot with the option, plain live count without).
    bus.start_stop = 1'b1; cycles(1); bus.start_stop = 1'b0;
    cycles(1230);
    check("lap_pre_0123", bus.number, 16'h0123);
    bus.lap = 1'b1; cycles(1); bus.lap = 1'b0;
    check("lap_capture", bus.number, 16'h0123);
    cycles(199);
    check("lap_after_200", bus.number, lap_expect);
    bus.lap = 1'b1; cycles(1); bus.lap = 1'b0;
    check("lap_release", bus.number, 16'h0143);

    // Asynchronous reset mid-count.
    cycles(2139);
    check("pre_reset_0357", bus.number, 16'h0357);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_number",  bus.number,        16'h0000);
    check("async_rst_running", 16'(bus.running),  16'h0000);
    check("async_rst_ovf",     16'(bus.overflow), 16'h0000);
    #2;
    rst_n = 1'b1;
    cycles(20);
    check("post_reset_idle", bus.number, 16'h0000);

    // Saturation on the DIV=2 instance: 9999 after 19998 cycles, then hold.
    fbus.start_stop = 1'b1; cycles(1); fbus.start_stop = 1'b0;
    cycles(19998);
    check("sat_pre_9999",     fbus.number,        16'h9999);
    check("sat_pre_running",  16'(fbus.running),  16'h0001);
    cycles(1);
    check("sat_pre_overflow", 16'(fbus.overflow), 16'h0000);
    cycles(1);
    check("sat_number",   fbus.number,        16'h9999);
    check("sat_overflow", 16'(fbus.overflow), 16'h0001);
    check("sat_running",  16'(fbus.running),  16'h0000);
    fbus.start_stop = 1'b1; cycles(1); fbus.start_stop = 1'b0;
    cycles(20);
    check("sat_ss_ignored_num", fbus.number,        16'h9999);
    check("sat_ss_ignored_ovf", 16'(fbus.overflow), 16'h0001);
    fbus.clear = 1'b1; cycles(1); fbus.clear = 1'b0;
    check("sat_clear_number",   fbus.number,        16'h0000);
    check("sat_clear_overflow", 16'(fbus.overflow), 16'h0000);
    check("sat_clear_running",  16'(fbus.running),  16'h0000);
    fbus.start_stop = 1'b1; cycles(1); fbus.start_stop = 1'b0;
    cycles(1);
    check("restart_early", fbus.number, 16'h0000);
    cycles(1);
    check("restart_tick", fbus.number, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
